// File: rtl/seq_nonrestoring_divider.sv
// -----------------------------------------------------------------------------
// seq_nonrestoring_divider
//
// Iterative non-restoring integer divider. One quotient bit is produced per
// clock, followed by a single remainder-correction cycle, so the combinational
// depth is one WIDTH+1 bit add/subtract regardless of WIDTH.
//
// Optional feature macro: NRD_SIGNED_EN
//   undefined : unsigned division only, no is_signed port.
//   defined   : adds is_signed; two's complement operands are divided as
//               magnitudes and the results are sign-fixed in the CORRECT cycle
//               (truncating division, latency unchanged).
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset, clears all state
//   start        divide request, only honoured in IDLE
//   is_signed    (NRD_SIGNED_EN only) operands are two's complement
//   dividend     numerator, captured on an accepted start
//   divisor      denominator, captured on an accepted start
//   busy         high while iterating / correcting
//   done         one-cycle pulse, results valid
//   quotient     result, held until replaced
//   remainder    result, held until replaced
//   div_by_zero  set with done when the divisor was zero
// -----------------------------------------------------------------------------
module seq_nonrestoring_divider #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef NRD_SIGNED_EN
  input  logic             is_signed,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CORRECT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH:0]     p_q, p_d;        // signed partial remainder
  logic [WIDTH-1:0]   a_q, a_d;        // dividend shifting out / quotient in
  logic [WIDTH-1:0]   dvs_q, dvs_d;    // divisor magnitude
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               zero_q, zero_d;  // current operation is a divide-by-zero
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               signed_s;
  logic               dividend_neg_s;
  logic               divisor_neg_s;
  logic [WIDTH-1:0]   dividend_mag_s;
  logic [WIDTH-1:0]   divisor_mag_s;
  logic [WIDTH:0]     dvs_ext_s;
  logic [WIDTH:0]     p_shift_s;
  logic [WIDTH:0]     p_next_s;
  logic [WIDTH-1:0]   rem_fix_s;

`ifdef NRD_SIGNED_EN
  assign signed_s = is_signed;
`else
  assign signed_s = 1'b0;
`endif

  assign dividend_neg_s = signed_s & dividend[WIDTH-1];
  assign divisor_neg_s  = signed_s & divisor[WIDTH-1];
  // Two's complement negation also maps the most-negative value onto its
  // unsigned magnitude, which is what the datapath needs.
  assign dividend_mag_s = dividend_neg_s ? (~dividend + {{(WIDTH-1){1'b0}}, 1'b1}) : dividend;
  assign divisor_mag_s  = divisor_neg_s  ? (~divisor  + {{(WIDTH-1){1'b0}}, 1'b1}) : divisor;

  assign dvs_ext_s = {1'b0, dvs_q};
  assign p_shift_s = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
  assign p_next_s  = p_q[WIDTH] ? (p_shift_s + dvs_ext_s) : (p_shift_s - dvs_ext_s);
  // The final remainder always lies in [0, divisor), so the correction only
  // needs the low WIDTH bits.
  assign rem_fix_s = p_q[WIDTH] ? (p_q[WIDTH-1:0] + dvs_q) : p_q[WIDTH-1:0];

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    a_d       = a_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    zero_d    = zero_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          p_d       = '0;
          cnt_d     = CNT_W'(WIDTH);
          dbz_d     = 1'b0;
          neg_quo_d = dividend_neg_s ^ divisor_neg_s;
          neg_rem_d = dividend_neg_s;
          dvs_d     = divisor_mag_s;
          if (divisor == '0) begin
            // Keep the raw dividend: it is returned unchanged as the remainder.
            // The zero case still passes through CORRECT so that done arrives
            // one cycle after the accepting edge.
            zero_d  = 1'b1;
            a_d     = dividend;
            state_d = CORRECT;
          end else begin
            zero_d  = 1'b0;
            a_d     = dividend_mag_s;
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        p_d   = p_next_s;
        a_d   = {a_q[WIDTH-2:0], ~p_next_s[WIDTH]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = CORRECT;
        end else begin
          state_d = RUN;
        end
      end

      CORRECT: begin
        if (zero_q) begin
          quo_d = '1;
          rem_d = a_q;
          dbz_d = 1'b1;
        end else begin
          p_d   = {1'b0, rem_fix_s};
          quo_d = neg_quo_q ? (~a_q + {{(WIDTH-1){1'b0}}, 1'b1}) : a_q;
          rem_d = neg_rem_q ? (~rem_fix_s + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_fix_s;
          dbz_d = 1'b0;
        end
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN) || (state_d == CORRECT);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      p_q       <= '0;
      a_q       <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      zero_q    <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      a_q       <= a_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      zero_q    <= zero_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_nonrestoring_divider.sv
// Self-checking bench for seq_nonrestoring_divider (WIDTH = 16).
module tb_seq_nonrestoring_divider;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          busy;
  logic          done;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic          div_by_zero;
`ifdef NRD_SIGNED_EN
  logic          is_signed;
`endif

  seq_nonrestoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef NRD_SIGNED_EN
    .is_signed   (is_signed),
`endif
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Model state: the operation in flight and the results currently held.
  bit           active = 1'b0;
  int           acc_cyc = 0;
  int           done_cyc = 0;
  logic [W-1:0] pq, pr, pa, pb;
  bit           pdbz, pinv;
  logic [W-1:0] m_q = '0;
  logic [W-1:0] m_r = '0;
  bit           m_dbz = 1'b0;
  bit           in_op, exp_done, exp_busy;
  longint       recon;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Single compare process: outputs checked against the model every cycle.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_quotient", 32'(quotient), 32'd0);
      chk("rst_remainder", 32'(remainder), 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
    end else begin
      in_op    = active && (cyc >= acc_cyc);
      exp_done = active && (cyc == done_cyc);
      exp_busy = in_op && (cyc < done_cyc);
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(exp_busy));
      if (exp_done) begin
        chk("quotient", 32'(quotient), 32'(pq));
        chk("remainder", 32'(remainder), 32'(pr));
        chk("div_by_zero", 32'(div_by_zero), 32'(pdbz));
        if (pinv) begin
          recon = longint'(quotient) * longint'(pb) + longint'(remainder);
          chk("invariant", recon[31:0], 32'(pa));
          chk("rem_lt_div", 32'(remainder < pb), 32'd1);
        end
        m_q    = pq;
        m_r    = pr;
        m_dbz  = pdbz;
        active = 1'b0;
      end else if (in_op) begin
        chk("dbz_cleared", 32'(div_by_zero), 32'd0);
      end else begin
        chk("held_quotient", 32'(quotient), 32'(m_q));
        chk("held_remainder", 32'(remainder), 32'(m_r));
        chk("held_dbz", 32'(div_by_zero), 32'(m_dbz));
      end
    end
  end

  // Issue one start; expected results from hand literals or the arithmetic model.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                       input bit use_lit, input logic [W-1:0] eq, input logic [W-1:0] er);
    int sa, sb, qq, rr;
    @(posedge clk); #1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
`ifdef NRD_SIGNED_EN
    is_signed = sgn;
`endif
    pa = a;
    pb = b;
    if (b == '0) begin
      pq   = '1;
      pr   = a;
      pdbz = 1'b1;
    end else if (sgn) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      qq = sa / sb;
      rr = sa % sb;
      pq = qq[W-1:0];
      pr = rr[W-1:0];
      pdbz = 1'b0;
    end else begin
      pq   = a / b;
      pr   = a % b;
      pdbz = 1'b0;
    end
    if (use_lit) begin
      pq = eq;
      pr = er;
    end
    pinv     = !sgn && (b != '0);
    acc_cyc  = cyc + 1;
    done_cyc = acc_cyc + ((b == '0) ? 1 : W + 1);
    active   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && active; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (active) begin
      errors++;
      $display("FAIL timeout: operation still pending, required completion by cycle %0d", done_cyc);
      active = 1'b0;
    end
  endtask

  task automatic div_lit(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                         input logic [W-1:0] eq, input logic [W-1:0] er);
    issue(a, b, sgn, 1'b1, eq, er);
    wait_idle();
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef NRD_SIGNED_EN
    is_signed = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    div_lit(16'd90,    16'd33,    1'b0, 16'd2,     16'd24);
    div_lit(16'd901,   16'd300,   1'b0, 16'd3,     16'd1);
    div_lit(16'd7,     16'd9,     1'b0, 16'd0,     16'd7);
    div_lit(16'd65535, 16'd1,     1'b0, 16'd65535, 16'd0);
    div_lit(16'd65535, 16'd65535, 1'b0, 16'd1,     16'd0);
    div_lit(16'd5,     16'd0,     1'b0, 16'hFFFF,  16'd5);
    div_lit(16'd10,    16'd3,     1'b0, 16'd3,     16'd1);

    // Start while busy and start during the done cycle are both ignored.
    issue(16'd100, 16'd7, 1'b0, 1'b1, 16'd14, 16'd2);
    repeat (3) @(posedge clk);
    #1;
    dividend = 16'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 60 && cyc != done_cyc; i++) begin
      @(posedge clk); #1;
    end
    dividend = 16'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk);

    // Reset mid-operation aborts without a done pulse.
    issue(16'd100, 16'd7, 1'b0, 1'b1, 16'd14, 16'd2);
    repeat (4) @(posedge clk);
    #1;
    rst    = 1'b1;
    active = 1'b0;
    m_q    = '0;
    m_r    = '0;
    m_dbz  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    div_lit(16'd1000, 16'd10, 1'b0, 16'd100, 16'd0);

`ifdef NRD_SIGNED_EN
    div_lit(16'hFFF9, 16'd2,    1'b1, 16'hFFFD, 16'hFFFF);
    div_lit(16'd7,    16'hFFFE, 1'b1, 16'hFFFD, 16'd1);
    div_lit(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'd0);
    div_lit(16'hFFFB, 16'd0,    1'b1, 16'hFFFF, 16'hFFFB);
    div_lit(16'd7,    16'hFFFE, 1'b0, 16'd0,    16'd7);
`endif

    // Unsigned sweep: model plus dividend == q*d + r, r < d.
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom) >> $urandom_range(0, 15);
      if (rb == '0) rb = 16'd1;
      issue(ra, rb, 1'b0, 1'b0, '0, '0);
      wait_idle();
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
